// File: rtl/clk_div_multi.sv
// ----------------------------------------------------------------------------
// clk_div_multi
//   NUM_CH independent integer clock dividers running entirely on clk_hf.
//   Each channel produces a one-cycle clock-enable pulse and a near-50% square
//   wave, both as flop outputs. Divisors are reprogrammed through a shadow
//   register that is only committed at phase 0, so a running period is never
//   truncated. sync_req forces every channel to phase 0 together, which keeps
//   integer-ratio channels edge-aligned.
//
// Ports
//   clk_hf      in   single input clock, all flops on its rising edge
//   rst_n       in   asynchronous active-low reset
//   div_in      in   requested divisor per channel, slice i = [i*CNT_W +: CNT_W]
//   div_load    in   per-channel load strobe
//   sync_req    in   realign all channels to phase 0
//   ce_out      out  per-channel enable pulse, one cycle per period
//   clk_out     out  per-channel divided square wave
//   div_ack     out  one-cycle pulse when a loaded divisor becomes active
//   div_active  out  divisor currently in effect per channel
// ----------------------------------------------------------------------------
module clk_div_multi #(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 8
) (
    input  logic                    clk_hf,
    input  logic                    rst_n,
    input  logic [NUM_CH*CNT_W-1:0] div_in,
    input  logic [NUM_CH-1:0]       div_load,
    input  logic                    sync_req,
    output logic [NUM_CH-1:0]       ce_out,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       div_ack,
    output logic [NUM_CH*CNT_W-1:0] div_active
);

    if (DEFAULT_DIV < 1 || DEFAULT_DIV > (2**CNT_W) - 1) begin : g_bad_default
        $error("clk_div_multi: DEFAULT_DIV out of range 1..2^CNT_W-1");
    end

    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt_q, div_q, shadow_q;
        logic             shadow_v_q;
        logic             ce_q, clk_q, ack_q;
        logic [CNT_W-1:0] cnt_n, div_n, shadow_n, din;
        logic             shadow_v_n, wrap, apply;

        assign din = div_in[i*CNT_W +: CNT_W];

        always_comb begin
            // sync_req behaves like a forced wrap: phase 0 plus pending apply.
            wrap       = sync_req || (cnt_q == div_q - ONE);
            // apply looks at shadow_v before this edge's load, so a load that
            // coincides with a wrap waits for the following one.
            apply      = wrap && shadow_v_q;
            cnt_n      = wrap ? '0 : cnt_q + ONE;
            div_n      = apply ? shadow_q : div_q;
            shadow_n   = shadow_q;
            shadow_v_n = shadow_v_q && !apply;
            if (div_load[i]) begin
                shadow_n   = (din == '0) ? ONE : din;
                shadow_v_n = 1'b1;
            end
        end

        always_ff @(posedge clk_hf or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q      <= '0;
                div_q      <= DEF_DIV;
                shadow_q   <= '0;
                shadow_v_q <= 1'b0;
                ce_q       <= 1'b0;
                clk_q      <= 1'b0;
                ack_q      <= 1'b0;
            end else begin
                cnt_q      <= cnt_n;
                div_q      <= div_n;
                shadow_q   <= shadow_n;
                shadow_v_q <= shadow_v_n;
                // Decode from next state so outputs match the count held
                // in the same cycle. With cnt_n==0 after sync this reduces to
                // ce=(div==1), clk=(div>=2) without a special case.
                ce_q       <= (cnt_n == div_n - ONE);
                clk_q      <= (cnt_n < (div_n >> 1));
                ack_q      <= apply;
            end
        end

        assign ce_out[i]                     = ce_q;
        assign clk_out[i]                    = clk_q;
        assign div_ack[i]                    = ack_q;
        assign div_active[i*CNT_W +: CNT_W]  = div_q;
    end

endmodule

// File: tb/tb_clk_div_multi.sv
module tb_clk_div_multi;
    localparam int NUM_CH = 2;
    localparam int CNT_W  = 8;
    localparam int DEF    = 4;

    logic                    clk_hf = 1'b0;
    logic                    rst_n;
    logic [NUM_CH*CNT_W-1:0] div_in;
    logic [NUM_CH-1:0]       div_load;
    logic                    sync_req;
    logic [NUM_CH-1:0]       ce_out, clk_out, div_ack;
    logic [NUM_CH*CNT_W-1:0] div_active;

    int n_chk  = 0;
    int n_fail = 0;

    clk_div_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
        .clk_hf(clk_hf), .rst_n(rst_n), .div_in(div_in), .div_load(div_load),
        .sync_req(sync_req), .ce_out(ce_out), .clk_out(clk_out),
        .div_ack(div_ack), .div_active(div_active)
    );

    always #5 clk_hf = ~clk_hf;

    // Reference model: position within the current period plus a pending slot.
    int  m_ph [NUM_CH];
    int  m_div[NUM_CH];
    int  m_sh [NUM_CH];
    bit  m_shv[NUM_CH];
    logic [NUM_CH-1:0]       e_ce, e_clk, e_ack;
    logic [NUM_CH*CNT_W-1:0] e_div;

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_ph[i] = 0; m_div[i] = DEF; m_sh[i] = 0; m_shv[i] = 0;
            e_div[i*CNT_W +: CNT_W] = CNT_W'(DEF);
        end
        e_ce = '0; e_clk = '0; e_ack = '0;
    endtask

    // Advance the model by one edge using the currently driven inputs, then
    // let the DUT take the same edge. Strobes are cleared afterwards.
    task automatic tick();
        for (int i = 0; i < NUM_CH; i++) begin
            bit wrap;
            int v;
            wrap = sync_req || (m_ph[i] == m_div[i] - 1);
            m_ph[i] = wrap ? 0 : m_ph[i] + 1;
            e_ack[i] = wrap && m_shv[i];
            if (wrap && m_shv[i]) begin
                m_div[i] = m_sh[i];
                m_shv[i] = 0;
            end
            if (div_load[i]) begin
                v = int'(div_in[i*CNT_W +: CNT_W]);
                m_sh[i]  = (v == 0) ? 1 : v;
                m_shv[i] = 1;
            end
            e_ce[i]  = (m_ph[i] == m_div[i] - 1);
            e_clk[i] = (m_ph[i] < m_div[i] / 2);
            e_div[i*CNT_W +: CNT_W] = CNT_W'(m_div[i]);
        end
        @(posedge clk_hf);
        #1;
        div_load = '0;
        sync_req = 1'b0;
    endtask

    task automatic test_reset();
        bit tc[8] = '{1,0,0,1,1,0,0,1};
        bit te[8] = '{0,0,1,0,0,0,1,0};
        rst_n = 1'b0; div_in = '0; div_load = '0; sync_req = 1'b0;
        model_reset();
        #12;
        n_chk++;
        if ({ce_out, clk_out, div_ack, div_active} !== {6'b0, 16'h0404}) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h",
                     {ce_out, clk_out, div_ack, div_active}, {6'b0, 16'h0404});
        end
        rst_n = 1'b1;
        #2;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_chk++;
            if ({ce_out, clk_out, div_ack} !== {te[k], te[k], tc[k], tc[k], 2'b00}) begin
                n_fail++;
                $display("FAIL reset_seq edge %0d: got ce=%b clk=%b ack=%b expected ce=%b clk=%b ack=00",
                         k + 1, ce_out, clk_out, div_ack, {te[k], te[k]}, {tc[k], tc[k]});
            end
        end
    endtask

    task automatic test_load5();
        int acks = 0, ces = 0, highs = 0;
        bit found = 0;
        tick();
        div_in[7:0] = 8'd5; div_load = 2'b01;
        tick();
        n_chk++;
        if (div_active[7:0] !== 8'd4 || div_ack[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL load5_pending: got div=%0d ack=%b expected div=4 ack=0", div_active[7:0], div_ack[0]);
        end
        for (int k = 0; k < 10 && !found; k++) begin
            tick();
            n_chk++;
            if ({ce_out, clk_out, div_ack, div_active} !== {e_ce, e_clk, e_ack, e_div}) begin
                n_fail++;
                $display("FAIL load5_model: got %h expected %h", {ce_out, clk_out, div_ack, div_active}, {e_ce, e_clk, e_ack, e_div});
            end
            if (div_ack[0]) acks++;
            if (e_ack[0]) found = 1;
        end
        n_chk++;
        if (!found || acks != 1 || div_active[7:0] !== 8'd5) begin
            n_fail++;
            $display("FAIL load5_apply: got acks=%0d div=%0d expected acks=1 div=5", acks, div_active[7:0]);
        end
        for (int k = 0; k < 15; k++) begin
            tick();
            ces += ce_out[0]; highs += clk_out[0];
        end
        n_chk++;
        if (ces != 3 || highs != 6) begin
            n_fail++;
            $display("FAIL load5_wave: got ce=%0d high=%0d expected ce=3 high=6", ces, highs);
        end
    endtask

    task automatic test_zero_load();
        int ces = 0, highs = 0;
        bit found = 0;
        div_in[7:0] = 8'd0; div_load = 2'b01;
        tick();
        for (int k = 0; k < 10 && !found; k++) begin
            tick();
            if (e_ack[0]) found = 1;
        end
        n_chk++;
        if (!found || div_active[7:0] !== 8'd1) begin
            n_fail++;
            $display("FAIL zero_clamp: got div=%0d expected 1", div_active[7:0]);
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            n_chk++;
            if (ce_out[0] !== 1'b1 || clk_out[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL div1_wave: got ce=%b clk=%b expected ce=1 clk=0", ce_out[0], clk_out[0]);
            end
        end
        div_in[7:0] = 8'd6; div_load = 2'b01;
        tick();
        tick();
        n_chk++;
        if (div_active[7:0] !== 8'd6 || div_ack[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL div6_apply: got div=%0d ack=%b expected div=6 ack=1", div_active[7:0], div_ack[0]);
        end
        for (int k = 0; k < 12; k++) begin
            tick();
            ces += ce_out[0]; highs += clk_out[0];
        end
        n_chk++;
        if (ces != 2 || highs != 6) begin
            n_fail++;
            $display("FAIL div6_wave: got ce=%0d high=%0d expected ce=2 high=6", ces, highs);
        end
    endtask

    task automatic test_sync();
        int c0 = 0, c1 = 0, r0 = 0, r1 = 0, bad = 0;
        logic [1:0] prev;
        bit found = 0;
        div_in = {8'd8, 8'd4}; div_load = 2'b11;
        tick();
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (!m_shv[0] && !m_shv[1]) found = 1;
        end
        n_chk++;
        if (!found || div_active !== 16'h0804) begin
            n_fail++;
            $display("FAIL sync_setup: got %h expected 0804", div_active);
        end
        for (int k = 0; k < int'($urandom_range(1, 7)); k++) tick();
        sync_req = 1'b1;
        tick();
        n_chk++;
        if ({ce_out, clk_out, div_ack} !== {2'b00, 2'b11, 2'b00}) begin
            n_fail++;
            $display("FAIL sync_phase0: got ce=%b clk=%b ack=%b expected ce=00 clk=11 ack=00", ce_out, clk_out, div_ack);
        end
        prev = clk_out;
        for (int k = 0; k < 16; k++) begin
            tick();
            c0 += ce_out[0]; c1 += ce_out[1];
            if (ce_out[1] && !ce_out[0]) bad++;
            if (clk_out[0] && !prev[0]) r0++;
            if (clk_out[1] && !prev[1]) begin
                r1++;
                if (!(clk_out[0] && !prev[0])) bad++;
            end
            prev = clk_out;
        end
        n_chk++;
        if (bad != 0 || c0 != 4 || c1 != 2 || r0 != 4 || r1 != 2) begin
            n_fail++;
            $display("FAIL sync_align: got bad=%0d ce0=%0d ce1=%0d rise0=%0d rise1=%0d expected 0 4 2 4 2",
                     bad, c0, c1, r0, r1);
        end
    endtask

    task automatic test_multi_load();
        int acks = 0;
        bit found = 0;
        div_in[7:0] = 8'd7; div_load = 2'b01;
        tick();
        if (div_ack[0]) acks++;
        div_in[7:0] = 8'd3; div_load = 2'b01;
        tick();
        if (div_ack[0]) acks++;
        for (int k = 0; k < 10 && m_ph[0] != m_div[0] - 1; k++) begin
            tick();
            if (div_ack[0]) acks++;
        end
        n_chk++;
        if (acks != 0 || m_ph[0] != m_div[0] - 1) begin
            n_fail++;
            $display("FAIL multi_preload: got acks=%0d expected 0 before wrap", acks);
        end
        div_in[7:0] = 8'd9; div_load = 2'b01;
        tick();
        n_chk++;
        if (div_active[7:0] !== 8'd3 || div_ack[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL multi_first: got div=%0d ack=%b expected div=3 ack=1", div_active[7:0], div_ack[0]);
        end
        acks = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick();
            if (div_ack[0]) acks++;
            if (e_ack[0]) found = 1;
        end
        n_chk++;
        if (!found || acks != 1 || div_active[7:0] !== 8'd9) begin
            n_fail++;
            $display("FAIL multi_second: got acks=%0d div=%0d expected acks=1 div=9", acks, div_active[7:0]);
        end
    endtask

    task automatic test_reset_mid();
        bit tc[8] = '{1,0,0,1,1,0,0,1};
        bit te[8] = '{0,0,1,0,0,0,1,0};
        div_in = {8'd2, 8'd11}; div_load = 2'b11;
        tick();
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({ce_out, clk_out, div_ack, div_active} !== {6'b0, 16'h0404}) begin
            n_fail++;
            $display("FAIL reset_async: got %h expected %h",
                     {ce_out, clk_out, div_ack, div_active}, {6'b0, 16'h0404});
        end
        model_reset();
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_chk++;
            if ({ce_out, clk_out, div_ack, div_active} !== {te[k], te[k], tc[k], tc[k], 2'b00, 16'h0404}) begin
                n_fail++;
                $display("FAIL reset_mid_seq edge %0d: got ce=%b clk=%b ack=%b div=%h",
                         k + 1, ce_out, clk_out, div_ack, div_active);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                div_in[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 12));
                div_load[i] = ($urandom_range(0, 7) == 0);
            end
            sync_req = ($urandom_range(0, 31) == 0);
            tick();
            n_chk++;
            if ({ce_out, clk_out, div_ack, div_active} !== {e_ce, e_clk, e_ack, e_div}) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %h expected %h", k,
                         {ce_out, clk_out, div_ack, div_active}, {e_ce, e_clk, e_ack, e_div});
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_load5();
        test_zero_load();
        test_sync();
        test_multi_load();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
